// File: rtl/div_pkg.sv
// Shared definitions for the RV32M divide unit: op encodings, result constants
// and the operand-stage payload.
package div_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned DIV_TAG_W = 5;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
   localparam logic [XLEN-1:0] OVF_Q   = 32'h8000_0000;
   localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;
   localparam logic [XLEN-1:0] NEG_ONE = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [XLEN-1:0]      abs_a;
      logic [XLEN-1:0]      abs_b;
      logic [XLEN-1:0]      raw_a;
      div_op_e              op;
      logic [DIV_TAG_W-1:0] tag;
      logic                 div0;
      logic                 ovf;
      logic                 neg_q;
      logic                 neg_r;
   } s1_payload_t;

   function automatic logic is_signed_op(div_op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_rem_op(div_op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   // INT_MIN maps to itself, which is its correct unsigned magnitude.
   function automatic logic [XLEN-1:0] abs_val(logic [XLEN-1:0] v);
      return v[XLEN-1] ? -v : v;
   endfunction

endpackage

// File: rtl/divider_unsigned.sv
// Combinational restoring divider: one compare/subtract row per quotient bit.
// Divide by zero yields an all-ones quotient; callers special-case it.
module divider_unsigned
   import div_pkg::*;
(
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_quotient,
   output logic [XLEN-1:0] o_remainder
);

   logic [XLEN:0]   partial;
   logic [XLEN-1:0] quo;

   always_comb begin
      partial = '0;
      quo     = '0;
      for (int i = XLEN - 1; i >= 0; i--) begin
         partial = {partial[XLEN-1:0], i_dividend[i]};
         if (partial >= {1'b0, i_divisor}) begin
            partial = partial - {1'b0, i_divisor};
            quo[i]  = 1'b1;
         end
      end
      o_quotient  = quo;
      o_remainder = partial[XLEN-1:0];
   end

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: operand register, combinational divider,
// sign-fixing result register, valid/ready on both sides.
module div_unit
   import div_pkg::*;
#(
   // Must equal DIV_TAG_W, which sizes the tag field of the S1 payload.
   parameter int unsigned TAG_W = DIV_TAG_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [1:0]       i_op,
   input  logic [31:0]      i_rs1,
   input  logic [31:0]      i_rs2,
   input  logic [TAG_W-1:0] i_tag,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [31:0]      o_result,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_busy
);

   logic        s1_valid;
   logic        s2_valid;
   logic        s1_adv;
   logic        s2_adv;
   logic        accept;
   s1_payload_t s1_d;
   s1_payload_t s1_q;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;
   logic [XLEN-1:0] result_d;

   assign s2_adv  = !s2_valid | i_ready;
   assign s1_adv  = !s1_valid | s2_adv;
   assign o_ready = s1_adv;
   assign accept  = i_valid & o_ready;
   assign o_valid = s2_valid;
   assign o_busy  = s1_valid | s2_valid;

   always_comb begin
      logic sgn;
      sgn        = is_signed_op(div_op_e'(i_op));
      s1_d       = '0;
      s1_d.abs_a = sgn ? abs_val(i_rs1) : i_rs1;
      s1_d.abs_b = sgn ? abs_val(i_rs2) : i_rs2;
      s1_d.raw_a = i_rs1;
      s1_d.op    = div_op_e'(i_op);
      s1_d.tag   = i_tag;
      s1_d.div0  = (i_rs2 == '0);
      s1_d.ovf   = sgn & (i_rs1 == INT_MIN) & (i_rs2 == NEG_ONE);
      s1_d.neg_q = sgn & (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]);
      s1_d.neg_r = sgn & i_rs1[XLEN-1];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (i_flush) begin
         s1_valid <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= accept;
         if (accept) begin
            s1_q <= s1_d;
         end
      end
   end

   divider_unsigned u_divider (
      .i_dividend  (s1_q.abs_a),
      .i_divisor   (s1_q.abs_b),
      .o_quotient  (quo),
      .o_remainder (rem)
   );

   // Special cases override the array output; div0 wins over ovf.
   always_comb begin
      q_fix = s1_q.neg_q ? -quo : quo;
      r_fix = s1_q.neg_r ? -rem : rem;
      if (s1_q.div0) begin
         result_d = is_rem_op(s1_q.op) ? s1_q.raw_a : DIV0_Q;
      end else if (s1_q.ovf) begin
         result_d = is_rem_op(s1_q.op) ? '0 : OVF_Q;
      end else begin
         result_d = is_rem_op(s1_q.op) ? r_fix : q_fix;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_valid <= 1'b0;
         o_result <= '0;
         o_tag    <= '0;
      end else if (i_flush) begin
         s2_valid <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            o_result <= result_d;
            o_tag    <= s1_q.tag;
         end
      end
   end

endmodule
